fifo_rd_stream: RTL and testbench

Read-side drain engine for the team's dual-clock FIFO. It runs in the `rclk` domain and pops entries whenever the FIFO is non-empty and buffer space exists. It absorbs the FIFO's one-cycle registered read latency in a 2-entry output buffer and presents the data as a valid/ready stream to downstream logic. It also provides a flush sequence that discards all buffered and queued data.

---
 rtl/fifo_rd_stream.sv | 107 ++++++++++
 tb/tb_fifo_rd_stream.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: pops the dual-clock FIFO into a 2-entry buffer and presents a valid/ready stream.
// Optional accepted-beat counter (beat_cnt) is included when FIFO_RD_STREAM_CNT_EN is defined.
module fifo_rd_stream #(
  parameter int WIDTH = 8
) (
  input  logic             rclk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic             flush_done
`ifdef FIFO_RD_STREAM_CNT_EN
  , output logic [15:0]    beat_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

  state_t                    r_state;
  logic [1:0][WIDTH-1:0]     r_buf;
  logic                      r_wptr;
  logic                      r_rptr;
  logic [1:0]                r_occ;
  logic                      r_rd_q;
  logic                      r_flush_done;

  logic                      w_pop;
  logic [1:0]                w_proj;
  logic                      w_flush_fin;

  assign m_valid    = (r_occ != 2'd0);
  assign m_data     = r_buf[r_rptr];
  assign flush_done = r_flush_done;

  assign w_pop       = m_valid & m_ready;
  // Occupancy after this cycle's landing read and pop; issuing only below 2 keeps the buffer from overrunning.
  assign w_proj      = r_occ + 2'(r_rd_q) - 2'(w_pop);
  assign w_flush_fin = (r_state == S_FLUSH) & fifo_empty & ~r_rd_q;

  always_comb begin
    fifo_rd_en = 1'b0;
    case (r_state)
      S_STREAM: fifo_rd_en = en & ~fifo_empty & (w_proj < 2'd2);
      S_FLUSH:  fifo_rd_en = ~fifo_empty;
      default:  fifo_rd_en = 1'b0;
    endcase
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_buf        <= '0;
      r_wptr       <= 1'b0;
      r_rptr       <= 1'b0;
      r_occ        <= 2'd0;
      r_rd_q       <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_rd_q       <= fifo_rd_en;
      r_flush_done <= 1'b0;
      case (r_state)
        S_IDLE: r_state <= S_STREAM;
        S_STREAM: begin
          if (flush) begin
            // Anything landing this cycle or later is dropped; a same-cycle pop was already accepted.
            r_state <= S_FLUSH;
            r_occ   <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
          end else begin
            if (r_rd_q) begin
              r_buf[r_wptr] <= fifo_dout;
              r_wptr        <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            r_occ <= w_proj;
          end
        end
        S_FLUSH: begin
          if (w_flush_fin) begin
            r_flush_done <= 1'b1;
            r_state      <= S_STREAM;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [15:0] r_beat_cnt;

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n)           r_beat_cnt <= 16'd0;
    else if (w_flush_fin) r_beat_cnt <= 16'd0;
    else if (w_pop)       r_beat_cnt <= r_beat_cnt + 16'd1;
  end

  assign beat_cnt = r_beat_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream with a behavioural registered-read FIFO.
// Define FIFO_RD_STREAM_CNT_EN to also exercise beat_cnt.
module tb_fifo_rd_stream;

  logic       rclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       flush = 1'b0;
  logic       m_ready = 1'b0;
  logic [7:0] fifo_dout = 8'h00;
  wire        fifo_empty;
  wire        fifo_rd_en;
  wire        m_valid;
  wire  [7:0] m_data;
  wire        flush_done;
`ifdef FIFO_RD_STREAM_CNT_EN
  wire [15:0] beat_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int n_push = 0;
  int n_pop = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  fifo_rd_stream #(.WIDTH(8)) dut (
    .rclk(rclk), .rst_n(rst_n), .en(en), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .flush_done(flush_done)
`ifdef FIFO_RD_STREAM_CNT_EN
    , .beat_cnt(beat_cnt)
`endif
  );

  always #5 rclk = ~rclk;

  // FIFO model: pop in cycle N, data on fifo_dout in N+1.
  assign fifo_empty = (n_push == n_pop);
  always @(posedge rclk) begin
    if (fifo_rd_en && fifo_q.size() != 0) begin
      fifo_dout <= fifo_q.pop_front();
      n_pop     <= n_pop + 1;
    end
  end

  task automatic push(input logic [7:0] d, input bit keep);
    fifo_q.push_back(d);
    n_push = n_push + 1;
    if (keep) exp_q.push_back(d);
  endtask

  task automatic nxt();
    @(posedge rclk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; m_ready = 1'b1;
    push(8'h11, 1); push(8'h22, 1); push(8'h33, 1);
    @(negedge rclk);
    n_chk++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en); end
    n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    n_chk++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL rst_m_data: got %h want 00", m_data); end
    n_chk++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL rst_flush_done: got %b want 0", flush_done); end
`ifdef FIFO_RD_STREAM_CNT_EN
    n_chk++; if (beat_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_beat_cnt: got %0d want 0", beat_cnt); end
`endif
    nxt(); nxt();
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int rd_c[$];
    int beats = 0;
    int reads = 0;
    logic [7:0] e;
    for (int k = 0; k < 12; k++) begin
      @(negedge rclk);
      if (k == 0) begin
        n_chk++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL basic_idle_rd: got %b want 0", fifo_rd_en); end
      end
      if (k == 1) begin
        n_chk++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL basic_first_rd: got %b want 1", fifo_rd_en); end
      end
      n_chk++; if ((fifo_rd_en & fifo_empty) !== 1'b0) begin n_fail++; $display("FAIL basic_rd_when_empty: cycle %0d", k); end
      if (fifo_rd_en) begin rd_c.push_back(k); reads++; end
      if (m_valid && m_ready) begin
        beats++;
        n_chk++;
        if (exp_q.size() == 0 || rd_c.size() == 0) begin n_fail++; $display("FAIL basic_extra_beat: data %h", m_data); end
        else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin n_fail++; $display("FAIL basic_data: got %h want %h", m_data, e); end
          n_chk++;
          if (k != rd_c[0] + 2) begin n_fail++; $display("FAIL basic_latency: beat cycle %0d want %0d", k, rd_c[0] + 2); end
          void'(rd_c.pop_front());
        end
      end
      nxt();
    end
    n_chk++; if (beats != 3) begin n_fail++; $display("FAIL basic_beats: got %0d want 3", beats); end
    n_chk++; if (reads != 3) begin n_fail++; $display("FAIL basic_reads: got %0d want 3", reads); end
  endtask

  task automatic test_backpressure();
    int reads = 0;
    int beats = 0;
    logic [7:0] e;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h40 + 8'(i), 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge rclk);
      if (fifo_rd_en) reads++;
      if (m_valid) begin
        n_chk++; if (m_data !== 8'h40) begin n_fail++; $display("FAIL bp_hold: got %h want 40", m_data); end
      end
      nxt();
    end
    n_chk++; if (reads != 2) begin n_fail++; $display("FAIL bp_reads: got %0d want 2", reads); end
    n_chk++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b want 1", m_valid); end
    m_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge rclk);
      if (m_valid && m_ready) begin
        beats++;
        n_chk++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_extra_beat: data %h", m_data); end
        else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin n_fail++; $display("FAIL bp_data: got %h want %h", m_data, e); end
        end
      end
      nxt();
    end
    n_chk++; if (beats != 5) begin n_fail++; $display("FAIL bp_beats: got %0d want 5", beats); end
  endtask

  task automatic test_flush();
    int dn = 0;
    int beats = 0;
    logic [7:0] e;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'h80 + 8'(i), 0);
    repeat (5) nxt();
    @(negedge rclk);
    n_chk++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL fl_pre_valid: got %b want 1", m_valid); end
    nxt();
    flush = 1'b1;
    nxt();
    flush = 1'b0;
    @(negedge rclk);
    n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid_drop: got %b want 0", m_valid); end
    for (int k = 0; k < 20; k++) begin
      if (flush_done) dn++;
      n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid: got %b want 0", m_valid); end
      nxt();
      @(negedge rclk);
    end
    n_chk++; if (dn != 1) begin n_fail++; $display("FAIL fl_done_pulses: got %0d want 1", dn); end
    n_chk++; if (fifo_q.size() != 0) begin n_fail++; $display("FAIL fl_drain: got %0d left want 0", fifo_q.size()); end
    nxt();
    m_ready = 1'b1;
    push(8'hA5, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge rclk);
      if (m_valid && m_ready) begin
        beats++;
        n_chk++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL fl_extra_beat: data %h", m_data); end
        else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin n_fail++; $display("FAIL fl_data: got %h want %h", m_data, e); end
        end
      end
      nxt();
    end
    n_chk++; if (beats != 1) begin n_fail++; $display("FAIL fl_beats: got %0d want 1", beats); end
  endtask

  task automatic test_enable();
    int beats = 0;
    logic [7:0] e;
    m_ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 6; i++) push(8'h60 + 8'(i), 1);
    for (int k = 0; k < 30; k++) begin
      @(negedge rclk);
      if (k >= 4 && k < 10) begin
        n_chk++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL en_rd_off: got %b want 0 cycle %0d", fifo_rd_en, k); end
      end
      if (m_valid && m_ready) begin
        beats++;
        n_chk++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL en_extra_beat: data %h", m_data); end
        else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin n_fail++; $display("FAIL en_data: got %h want %h", m_data, e); end
        end
      end
      nxt();
      if (k == 3) en = 1'b0;
      if (k == 9) en = 1'b1;
    end
    n_chk++; if (beats != 6) begin n_fail++; $display("FAIL en_beats: got %0d want 6", beats); end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    m_ready = 1'b0;
    push(8'h90, 0); push(8'h91, 0);
    repeat (4) nxt();
    @(negedge rclk);
    n_chk++; if (m_valid !== 1'b1 || m_data !== 8'h90) begin n_fail++; $display("FAIL rm_pre: got v=%b d=%h want v=1 d=90", m_valid, m_data); end
    nxt();
    rst_n = 1'b0;
    #1;
    n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b want 0", m_valid); end
    n_chk++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL rm_data: got %h want 00", m_data); end
    n_chk++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rm_rd_en: got %b want 0", fifo_rd_en); end
    n_chk++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL rm_flush_done: got %b want 0", flush_done); end
`ifdef FIFO_RD_STREAM_CNT_EN
    n_chk++; if (beat_cnt !== 16'd0) begin n_fail++; $display("FAIL rm_beat_cnt: got %0d want 0", beat_cnt); end
`endif
    nxt(); nxt();
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge rclk);
      if (m_valid) stale++;
      nxt();
    end
    n_chk++; if (stale != 0) begin n_fail++; $display("FAIL rm_stale: got %0d beats want 0", stale); end
  endtask

  task automatic test_counter();
`ifdef FIFO_RD_STREAM_CNT_EN
    int acc = 0;
    int pushed = 0;
    bit seen = 0;
    logic [7:0] e;
    n_chk++; if (beat_cnt !== 16'd0) begin n_fail++; $display("FAIL cnt_start: got %0d want 0", beat_cnt); end
    m_ready = 1'b1; en = 1'b1;
    for (int k = 0; k < 75000 && acc < 70000; k++) begin
      @(negedge rclk);
      if (m_valid && m_ready) begin
        acc++;
        n_chk++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL cnt_extra_beat: data %h", m_data); end
        else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin n_fail++; $display("FAIL cnt_data: got %h want %h", m_data, e); end
        end
      end
      nxt();
      if (acc == 70000) m_ready = 1'b0;
      while (m_ready && fifo_q.size() < 3) begin push(8'(pushed), 1); pushed++; end
    end
    n_chk++; if (acc != 70000) begin n_fail++; $display("FAIL cnt_timeout: got %0d beats want 70000", acc); end
    @(negedge rclk);
    n_chk++; if (beat_cnt !== 16'd4464) begin n_fail++; $display("FAIL cnt_wrap: got %0d want 4464", beat_cnt); end
    nxt();
    flush = 1'b1;
    nxt();
    flush = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge rclk);
      if (flush_done) begin
        seen = 1;
        n_chk++; if (beat_cnt !== 16'd0) begin n_fail++; $display("FAIL cnt_flush_clr: got %0d want 0", beat_cnt); end
      end
      nxt();
    end
    n_chk++; if (!seen) begin n_fail++; $display("FAIL cnt_flush_timeout: flush_done got 0 want 1"); end
    exp_q.delete();
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_enable();
    test_reset_mid();
    test_counter();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
